// File: rtl/pcileech_rst_seq.sv
// pcileech_rst_seq: lock-filtered, staggered multi-domain reset sequencer.
// Optional PERST# handling is enabled by defining PCILEECH_RST_SEQ_PERST_EN.
module pcileech_rst_seq #(
    parameter int NUM_DOMAINS    = 3,
    parameter int HOLD_CYCLES    = 64,
    parameter int STAGGER_CYCLES = 16,
    parameter int LOCK_FILTER    = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clk_locked,
    input  logic                   pcie_perst_n,
    input  logic                   sw_rst_req,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   all_released,
    output logic [2:0]             seq_state,
    output logic [15:0]            rst_count,
    output logic [63:0]            tickcount64
);

    localparam int LW = $clog2(LOCK_FILTER + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = $clog2((NUM_DOMAINS - 1) * STAGGER_CYCLES + 2);

    localparam logic [NUM_DOMAINS-1:0] ALL_ON    = {NUM_DOMAINS{1'b1}};
    localparam logic [NUM_DOMAINS-1:0] FIRST_OFF = ALL_ON << 1;

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_HOLD      = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3
    } state_e;

    state_e                 state_q;
    logic [LW-1:0]          filt_q;
    logic [LW-1:0]          filt_d;
    logic [HW-1:0]          hold_q;
    logic [HW-1:0]          hold_d;
    logic [SW-1:0]          stag_q;
    logic [SW-1:0]          stag_d;
    logic [NUM_DOMAINS-1:0] rst_out_q;
    logic [NUM_DOMAINS-1:0] rel_clr;
    logic [NUM_DOMAINS-1:0] rst_rel_d;
    logic                   all_rel_q;
    logic [15:0]            rst_count_q;
    logic [15:0]            rst_cnt_d;
    logic [63:0]            tick_q;
    logic [63:0]            tick_d;

    logic lock_meta_q;
    logic lock_s_q;
    logic perst_s;
    logic perst_fall;
    logic restart;

    // Two-flop synchroniser for the clock-wizard lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= clk_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

`ifdef PCILEECH_RST_SEQ_PERST_EN
    logic perst_meta_q;
    logic perst_s_q;
    logic perst_prev_q;

    // Two-flop PERST# synchroniser plus one delay flop for fall detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perst_meta_q <= 1'b0;
            perst_s_q    <= 1'b0;
            perst_prev_q <= 1'b0;
        end else begin
            perst_meta_q <= pcie_perst_n;
            perst_s_q    <= perst_meta_q;
            perst_prev_q <= perst_s_q;
        end
    end

    assign perst_s    = perst_s_q;
    assign perst_fall = perst_prev_q & ~perst_s_q;
`else
    logic unused_perst;

    assign unused_perst = pcie_perst_n;
    assign perst_s      = 1'b1;
    assign perst_fall   = 1'b0;
`endif

    assign tick_d    = tick_q + 64'd1;
    assign filt_d    = filt_q + 1'b1;
    assign hold_d    = hold_q + 1'b1;
    assign stag_d    = stag_q + 1'b1;
    assign rst_cnt_d = (rst_count_q == 16'hFFFF) ? rst_count_q
                                                 : rst_count_q + 16'd1;

    // Lock loss outranks PERST#, which outranks the software request
    assign restart = ~lock_s_q | perst_fall | sw_rst_req;

    // Domains whose release slot lands on the next stagger count
    always_comb begin
        rel_clr = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            rel_clr[i] = (stag_d == SW'(i * STAGGER_CYCLES));
        end
        rst_rel_d = rst_out_q & ~rel_clr;
    end

    // Free-running shared cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    // Sequencer FSM with registered reset outputs and restart counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_WAIT_LOCK;
            filt_q      <= '0;
            hold_q      <= '0;
            stag_q      <= '0;
            rst_out_q   <= ALL_ON;
            all_rel_q   <= 1'b0;
            rst_count_q <= '0;
        end else if (state_q != S_WAIT_LOCK && restart) begin
            rst_out_q   <= ALL_ON;
            all_rel_q   <= 1'b0;
            rst_count_q <= rst_cnt_d;
            filt_q      <= '0;
            hold_q      <= '0;
            stag_q      <= '0;
            state_q     <= lock_s_q ? S_HOLD : S_WAIT_LOCK;
        end else begin
            unique case (state_q)
                S_WAIT_LOCK: begin
                    rst_out_q <= ALL_ON;
                    all_rel_q <= 1'b0;
                    if (!lock_s_q) begin
                        filt_q <= '0;
                    end else if (filt_d == LW'(LOCK_FILTER)) begin
                        filt_q  <= '0;
                        hold_q  <= '0;
                        state_q <= S_HOLD;
                    end else begin
                        filt_q <= filt_d;
                    end
                end
                S_HOLD: begin
                    if (!perst_s) begin
                        hold_q <= '0;
                    end else if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                        hold_q    <= '0;
                        stag_q    <= '0;
                        rst_out_q <= FIRST_OFF;
                        state_q   <= S_RELEASE;
                    end else begin
                        hold_q <= hold_d;
                    end
                end
                S_RELEASE: begin
                    stag_q    <= stag_d;
                    rst_out_q <= rst_rel_d;
                    if (!rst_rel_d[NUM_DOMAINS-1]) begin
                        state_q   <= S_RUN;
                        all_rel_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    rst_out_q <= '0;
                    all_rel_q <= 1'b1;
                end
                default: begin
                    rst_out_q <= ALL_ON;
                    all_rel_q <= 1'b0;
                    state_q   <= S_WAIT_LOCK;
                end
            endcase
        end
    end

    assign rst_out      = rst_out_q;
    assign all_released = all_rel_q;
    assign seq_state    = state_q;
    assign rst_count    = rst_count_q;
    assign tickcount64  = tick_q;

endmodule

// File: doc/pcileech_rst_seq.md
# pcileech_rst_seq

Parametrised reset sequencer for the PCILeech top level. It generalises the fixed 64-cycle tickcount power-on reset into a multi-domain sequencer that does four things. It waits for a filtered clock-wizard lock, holds reset for a programmable time, and then releases N reset domains in staggered order. It re-asserts reset on lock loss, PERST# or a software request. It sits between clk_wiz_0/BUFG and the com, fifo and pcie instances, and also exports the shared 64-bit tickcount.

## Interface
Parameters:
- NUM_DOMAINS, 3: number of reset outputs (1..8); domain 0 releases first.
- HOLD_CYCLES, 64: cycles reset is held after lock or after a restart (>=1).
- STAGGER_CYCLES, 16: spacing between consecutive domain releases (>=1).
- LOCK_FILTER, 8: consecutive synchronised lock-high cycles required (>=1).

Ports:
- clk  in  1  system clock (125 MHz).
- rst_n  in  1  asynchronous, active-low reset; one clock domain.
- clk_locked  in  1  clock-wizard lock, asynchronous; 2-flop synchronised.
- pcie_perst_n  in  1  PCIe PERST#, asynchronous, active-low; 2-flop synchronised.
- sw_rst_req  in  1  synchronous single-cycle software reset request.
- rst_out  out  NUM_DOMAINS  active-high domain resets, registered.
- all_released  out  1  high while state is RUN.
- seq_state  out  3  encoded state: 0 WAIT_LOCK, 1 HOLD, 2 RELEASE, 3 RUN.
- rst_count  out  16  saturating count of restarts.
- tickcount64  out  64  free-running cycle counter.

## Operation
- Reset (rst_n low) sets the following: state WAIT_LOCK, rst_out all 1, all_released 0, rst_count 0, tickcount64 0, internal counters 0, synchroniser flops 0.
- tickcount64 increments every cycle and wraps from 2^64-1 to 0. Only rst_n clears it.
- WAIT_LOCK: the lock filter counter increments while lock_s (synchronised clk_locked) is 1 and clears when lock_s is 0. When it reaches LOCK_FILTER, the block enters HOLD.
- HOLD: the hold counter counts 0..HOLD_CYCLES-1, then the block enters RELEASE. While perst_s is 0, the hold counter is held at 0.
- RELEASE: a stagger counter runs from 0.
  - rst_out[i] clears when the stagger counter equals i*STAGGER_CYCLES.
  - When rst_out[NUM_DOMAINS-1] clears, the block enters RUN.
  - If NUM_DOMAINS=1, RELEASE lasts one cycle.
- RUN: rst_out stays all 0 and all_released is 1.
- Restart events (evaluated in HOLD, RELEASE and RUN), listed in priority order:
  1. lock_s=0: rst_out goes all 1 and the block enters WAIT_LOCK.
  2. perst_s=0: rst_out goes all 1 and the block enters HOLD with the counter at 0.
  3. sw_rst_req=1: rst_out goes all 1 and the block enters HOLD with the counter at 0.
  - Simultaneous events: the highest-priority event wins. Only one rst_count increment occurs.
  - rst_count increments by 1 on every restart and saturates at 16'hFFFF.
  - The initial sequence after rst_n does not increment rst_count.
- In WAIT_LOCK, perst_s and sw_rst_req are ignored and rst_out stays all 1.

## Timing
- Synchroniser latency is 2 cycles.
- clk_locked falling to rst_out all 1: 3 cycles (2 sync + 1 register).
- pcie_perst_n falling to rst_out all 1: 3 cycles.
- sw_rst_req to rst_out all 1: 1 cycle; the state is HOLD on the same edge.
- Let T be the first cycle with state HOLD and perst_s=1:
  - rst_out[i] falls at cycle T+HOLD_CYCLES+i*STAGGER_CYCLES.
  - all_released rises in the cycle in which rst_out[NUM_DOMAINS-1] falls.
- With defaults and no events: LOCK_FILTER+2 cycles after clk_locked rises, HOLD begins. rst_out[0] falls 64 cycles later, rst_out[1] 80 cycles later, rst_out[2] 96 cycles later.
- A released domain never re-asserts except all-at-once on a restart. rst_out is never partially re-asserted.
- Asynchronous rst_n assertion mid-sequence forces all reset values immediately (asynchronously). Deassertion is sampled on the next clk edge.

## Configuration
- PCILEECH_RST_SEQ_PERST_EN defined: pcie_perst_n is synchronised and acts as described (hold in HOLD, restart event).
- Not defined: pcie_perst_n is ignored (the port is still present), perst_s is tied to 1, and no PERST restarts occur. All other behaviour is identical.

## Test plan
- Power-up: rst_n low 5 cycles, clk_locked=1 from cycle 10, defaults → HOLD at cycle 20; rst_out = 3'b110 at 84, 3'b100 at 100, 3'b000 at 116; all_released=1 at 116; rst_count=0.
- Lock glitch: clk_locked 1 for 5 cycles, 0 for 1, then 1 → filter restarts; HOLD entered only after 8 consecutive synced-high cycles.
- RUN lock loss: drop clk_locked in RUN → rst_out=3'b111 3 cycles later, seq_state=0, rst_count=1; relock repeats the full sequence.
- sw_rst_req during RELEASE (with rst_out=3'b110) → next cycle rst_out=3'b111, state HOLD; rst_out[0] falls 64 cycles later; rst_count increments by 1.
- Simultaneous sw_rst_req and perst assert in RUN with the macro defined → single restart, rst_count +1. Hold perst low 200 cycles → rst_out stays 3'b111; rst_out[0] falls 66 cycles after perst_n rises. With the macro undefined, perst is ignored.
- Saturation/wrap: preload rst_count=16'hFFFE and trigger 3 restarts → stays 16'hFFFF. Force tickcount64=2^64-1 → next cycle 0.
